ftoi_arbiter: RTL and testbench

//  Shares one combinational ftoi converter (float32 -> signed int32) among NREQ requesters.

---
 rtl/ftoi_arbiter.sv | 94 +++++++++
 tb/tb_ftoi_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ftoi_arbiter.sv
// ftoi_arbiter: round-robin access to one float32->int32 converter behind a 2-stage pipeline
module ftoi_arbiter #(
    parameter int NREQ = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic [31:0]          resp_data,
    output logic                 resp_exc
);
    // Returns {exc, data}; rounds to nearest with ties away from zero.
    function automatic logic [32:0] ftoi(input logic [31:0] f);
        logic [7:0] e;
        logic [23:0] m;
        logic [4:0] sh;
        logic [31:0] mag;
        e = f[30:23];
        m = {1'b1, f[22:0]};
        sh = '0;
        if (e < 8'd126)
            mag = '0;
        else if (e <= 8'd150) begin
            sh = 5'(8'd150 - e);
            mag = ({8'd0, m} + ((32'd1 << sh) >> 1)) >> sh;
        end else
            mag = {8'd0, m} << (e - 8'd150);
        return {(e >= 8'd158) && !(f[31] && e == 8'd158 && f[22:0] == 23'd0),
                f[31] ? -mag : mag};
    endfunction

    logic [ID_W-1:0] rr_ptr, win, c, s0_id;
    logic [31:0] s0_op, sel_op;
    logic [31:0] ops [NREQ];
    logic s0_valid, found, s1_adv, load_ok, accept;

    for (genvar i = 0; i < NREQ; i++) begin : g_ops
        assign ops[i] = req_data[32*i +: 32];
    end

    always_comb begin
        found = 1'b0;
        win = '0;
        c = '0;
        for (int k = 1; k <= NREQ; k++) begin
            c = ID_W'((int'(rr_ptr) + k) % NREQ);
            if (!found && req_valid[c]) begin
                found = 1'b1;
                win = c;
            end
        end
    end

    assign sel_op    = ops[win];
    assign s1_adv    = !resp_valid || resp_ready;
    assign load_ok   = !s0_valid || s1_adv;
    assign accept    = found && load_ok && !rst;
    assign req_ready = accept ? NREQ'(1) << win : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= ID_W'(NREQ - 1);
            s0_valid   <= 1'b0;
            s0_id      <= '0;
            s0_op      <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
            resp_exc   <= 1'b0;
        end else begin
            if (accept)
                rr_ptr <= win;
            if (load_ok) begin
                s0_valid <= accept;
                if (accept) begin
                    s0_id <= win;
                    s0_op <= sel_op;
                end
            end
            if (s1_adv) begin
                resp_valid <= s0_valid;
                if (s0_valid) begin
                    resp_id <= s0_id;
                    {resp_exc, resp_data} <= ftoi(s0_op);
                end
            end
        end
    end
endmodule

// File: tb/tb_ftoi_arbiter.sv
// tb_ftoi_arbiter: table vectors, directed corner sequences and a scoreboarded random stream
module tb_ftoi_arbiter;
    localparam int NREQ = 4;
    localparam int ID_W = 2;
    typedef struct packed { logic [ID_W-1:0] id; logic [31:0] data; logic exc; } exp_t;
    typedef struct { int id; logic [31:0] op; logic [31:0] data; bit exc; } vec_t;

    logic clk = 1'b0, rst = 1'b1;
    logic [NREQ-1:0] req_valid = '0, req_ready, acc_q = '0;
    logic [NREQ-1:0][31:0] din = '0;
    logic resp_valid, resp_exc, resp_ready = 1'b1;
    logic [ID_W-1:0] resp_id, pid;
    logic [31:0] resp_data, pdata;
    logic pexc;
    bit pstall = 0, mf;
    int checks = 0, errors = 0, mode = 0, rr = NREQ - 1, resp_cnt = 0, mw, n0;
    exp_t sb[$];
    exp_t mx;

    always #5 clk = ~clk;

    ftoi_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_data(din),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_exc(resp_exc)
    );

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference converter built on real arithmetic rather than integer shifting.
    function automatic exp_t model(input logic [ID_W-1:0] id, input logic [31:0] f);
        exp_t x;
        real r, a;
        int e;
        e = int'(f[30:23]);
        x.id = id;
        x.data = '0;
        if (e == 255) begin
            x.exc = 1'b1;
            return x;
        end
        r = (e == 0) ? real'(f[22:0]) * (2.0 ** -149.0) : real'({1'b1, f[22:0]}) * (2.0 ** real'(e - 150));
        if (f[31]) r = -r;
        a = (r >= 0.0) ? $floor(r + 0.5) : -$floor(-r + 0.5);
        x.exc = (r >= 2147483648.0) || (r < -2147483648.0);
        if (!x.exc) x.data = 32'($rtoi(a));
        return x;
    endfunction

    function automatic logic [31:0] rand_float();
        logic [31:0] f;
        f = $urandom;
        if ($urandom_range(3, 0) != 0) f[30:23] = 8'($urandom_range(165, 110));
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc_q[i]) begin
                if (mode == 1 || (mode == 2 && $urandom_range(1, 0) == 1)) din[i] = rand_float();
                else req_valid[i] = 1'b0;
            end else if (mode == 2 && !req_valid[i] && $urandom_range(2, 0) == 0) begin
                req_valid[i] = 1'b1;
                din[i] = rand_float();
            end
        end
        if (mode == 2) resp_ready = ($urandom_range(3, 0) != 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = '0;
        resp_ready = 1'b1;
        mode = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 0;
        mode = 0;
        resp_ready = 1'b1;
        for (int c = 0; c < 60 && !done; c++) begin
            step();
            @(negedge clk);
            done = (req_valid == '0) && !resp_valid && (sb.size() == 0);
        end
        chk(done, name, sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            acc_q = '0;
            sb.delete();
            rr = NREQ - 1;
            pstall = 0;
            chk(req_ready == '0 && !resp_valid, "in_reset_idle", 32'(req_ready), 0);
        end else begin
            acc_q = req_valid & req_ready;
            chk($onehot0(req_ready) && (req_ready & ~req_valid) == '0, "ready_legal", 32'(req_ready), 32'(req_valid));
            if (pstall)
                chk(resp_valid && resp_id == pid && resp_data == pdata && resp_exc == pexc, "stall_stable", resp_data, pdata);
            if (resp_valid && resp_ready) begin
                chk(sb.size() != 0, "resp_expected", 32'(resp_id), 0);
                if (sb.size() != 0) begin
                    mx = sb.pop_front();
                    resp_cnt++;
                    chk(resp_id == mx.id, "resp_id", 32'(resp_id), 32'(mx.id));
                    chk(resp_exc == mx.exc, "resp_exc", 32'(resp_exc), 32'(mx.exc));
                    if (!mx.exc) chk(resp_data == mx.data, "resp_data", resp_data, mx.data);
                end
            end
            if (req_ready != '0) begin
                mf = 0;
                mw = 0;
                for (int k = 1; k <= NREQ; k++)
                    if (!mf && req_valid[(rr + k) % NREQ]) begin
                        mf = 1;
                        mw = (rr + k) % NREQ;
                    end
                chk(req_ready == (4'b1 << mw), "rr_grant", 32'(req_ready), 32'(4'b1 << mw));
                sb.push_back(model(ID_W'(mw), din[mw]));
                rr = mw;
            end
            pstall = resp_valid && !resp_ready;
            pid = resp_id;
            pdata = resp_data;
            pexc = resp_exc;
        end
    end

    initial begin
        vec_t tbl[15];
        bit acc, got;
        int lat;
        tbl[0]  = '{0, 32'h3FC00000, 32'h00000002, 1'b0};
        tbl[1]  = '{2, 32'hC0200000, 32'hFFFFFFFD, 1'b0};
        tbl[2]  = '{2, 32'hCF000000, 32'h80000000, 1'b0};
        tbl[3]  = '{2, 32'h4F000000, 32'h00000000, 1'b1};
        tbl[4]  = '{2, 32'h7FC00000, 32'h00000000, 1'b1};
        tbl[5]  = '{2, 32'h00000001, 32'h00000000, 1'b0};
        tbl[6]  = '{1, 32'h40200000, 32'h00000003, 1'b0};
        tbl[7]  = '{3, 32'h3F000000, 32'h00000001, 1'b0};
        tbl[8]  = '{3, 32'hBF000000, 32'hFFFFFFFF, 1'b0};
        tbl[9]  = '{1, 32'h3EFFFFFF, 32'h00000000, 1'b0};
        tbl[10] = '{0, 32'h4EFFFFFF, 32'h7FFFFF80, 1'b0};
        tbl[11] = '{0, 32'hCF000001, 32'h00000000, 1'b1};
        tbl[12] = '{1, 32'hFF800000, 32'h00000000, 1'b1};
        tbl[13] = '{3, 32'h80000000, 32'h00000000, 1'b0};
        tbl[14] = '{0, 32'h40A00000, 32'h00000005, 1'b0};

        req_valid = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk(req_ready == '0, "rst_ready", 32'(req_ready), 0);
        req_valid = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk(!resp_valid && resp_id == '0 && resp_data == '0 && !resp_exc, "reset_outputs", resp_data, 0);

        for (int v = 0; v < 15; v++) begin
            step();
            req_valid[tbl[v].id] = 1'b1;
            din[tbl[v].id] = tbl[v].op;
            acc = 0;
            for (int k = 0; k < 10 && !acc; k++) begin
                @(negedge clk);
                acc = req_ready[tbl[v].id];
                if (!acc) step();
            end
            chk(acc, $sformatf("tbl%0d_accept", v), 32'(req_ready), 32'(4'b1 << tbl[v].id));
            got = 0;
            lat = 0;
            for (int k = 1; k <= 6 && !got; k++) begin
                step();
                @(negedge clk);
                if (resp_valid) begin
                    got = 1;
                    lat = k;
                end
            end
            chk(got && lat == 2, $sformatf("tbl%0d_latency", v), lat, 2);
            chk(resp_id == ID_W'(tbl[v].id), $sformatf("tbl%0d_id", v), 32'(resp_id), tbl[v].id);
            chk(resp_exc == tbl[v].exc, $sformatf("tbl%0d_exc", v), 32'(resp_exc), 32'(tbl[v].exc));
            if (!tbl[v].exc) chk(resp_data == tbl[v].data, $sformatf("tbl%0d_data", v), resp_data, tbl[v].data);
        end

        mode = 1;
        step();
        req_valid = 4'b0001;
        din[0] = rand_float();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk(req_ready == 4'b0001, "single_b2b", 32'(req_ready), 1);
            step();
        end

        do_reset();
        mode = 1;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) din[i] = rand_float();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk(req_ready == (4'b1 << (c % NREQ)), "rotate_grant", 32'(req_ready), 32'(4'b1 << (c % NREQ)));
            if (c >= 2) chk(resp_valid && resp_id == ID_W'((c - 2) % NREQ), "rotate_resp_id", 32'(resp_id), (c - 2) % NREQ);
            step();
        end

        do_reset();
        resp_ready = 1'b0;
        req_valid = 4'b0111;
        din[0] = 32'h3F800000;
        din[1] = 32'h40000000;
        din[2] = 32'h40400000;
        n0 = resp_cnt;
        @(negedge clk);
        chk(req_ready == 4'b0001, "stall_fill0", 32'(req_ready), 1);
        step();
        @(negedge clk);
        chk(req_ready == 4'b0010, "stall_fill1", 32'(req_ready), 2);
        step();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk(req_ready == '0 && resp_valid && resp_id == '0 && resp_data == 32'd1, "stall_hold", resp_data, 1);
            step();
        end
        resp_ready = 1'b1;
        drain("stall_drain");
        chk(resp_cnt - n0 == 3, "stall_count", resp_cnt - n0, 3);

        do_reset();
        mode = 1;
        resp_ready = 1'b0;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) din[i] = rand_float();
        @(negedge clk);
        step();
        @(negedge clk);
        step();
        @(negedge clk);
        chk(resp_valid && req_ready == '0, "full_before_rst", 32'(req_ready), 0);
        #2 rst = 1'b1;
        #1;
        chk(!resp_valid && req_ready == '0, "async_rst_clear", 32'(resp_valid), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk(req_ready == 4'b0001 && !resp_valid, "first_grant_after_rst", 32'(req_ready), 1);

        do_reset();
        n0 = resp_cnt;
        mode = 2;
        repeat (600) step();
        drain("random_drain");
        chk(resp_cnt - n0 > 100, "random_activity", resp_cnt - n0, 101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
